stage_buffer: RTL and testbench

Parametrised elastic buffer between two pipeline stages of the riviera core, replacing the fixed single-register IF→ID→EX hand-off. Carries a WIDTH-bit payload under a valid/ready handshake, holds up to DEPTH entries so a stalled consumer does not stall the producer immediately, and supports a flush from EX. An optional combinational bypass is available when empty. A saturating stall counter is exposed for debug.

---
 rtl/stage_buffer_pkg.sv | 17 +
 rtl/stage_buffer.sv | 108 ++++++++++
 tb/tb_stage_buffer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_buffer_pkg.sv
// Shared definitions for the pipeline-stage elastic buffers of the riviera core.
// Provides the default depth, the IF->ID payload width and a debug statistics bundle.
package stage_buffer_pkg;

    localparam int RNG_64 = 64;
    localparam int RNG_32 = 32;

    localparam int STAGE_BUF_DEPTH = 2;
    // Fetch hand-off payload: program counter followed by the instruction word.
    localparam int IFID_PAYLOAD_W = RNG_64 + RNG_32;

    typedef struct packed {
        logic [15:0] stall_cnt;
        logic [4:0]  count;
    } stage_buf_stats_t;

endpackage

// File: rtl/stage_buffer.sv
// Elastic valid/ready buffer between two pipeline stages, with flush, an optional
// empty-buffer bypass and a saturating consumer-stall counter for debug.
module stage_buffer
    import stage_buffer_pkg::*;
#(
    parameter int WIDTH   = IFID_PAYLOAD_W,
    parameter int DEPTH   = STAGE_BUF_DEPTH,
    parameter int BYPASS  = 0,
    parameter int STALL_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [WIDTH-1:0]           i_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [WIDTH-1:0]           o_data,
    input  logic                       i_flush,
    input  logic                       i_clr_stats,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic [STALL_W-1:0]         o_stall_cnt
);

    localparam int   PTR_W  = $clog2(DEPTH);
    localparam int   CNT_W  = $clog2(DEPTH+1);
    localparam logic BYP_EN = (BYPASS != 0);

    generate
        if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("stage_buffer: DEPTH must be a power of two in 2..16");
        end
    endgenerate

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic empty;
    logic full;
    logic bypass_taken;
    logic push;
    logic pop;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_W'(DEPTH));
    assign o_ready      = !full;
    assign bypass_taken = BYP_EN & empty & i_valid & i_ready & !i_flush;
    assign push         = i_valid & o_ready & !i_flush & !bypass_taken;
    assign o_valid      = (!empty | (BYP_EN & i_valid)) & !i_flush;
    assign pop          = o_valid & i_ready & !i_flush & !empty;
    assign o_data       = (BYP_EN && empty) ? i_data : mem_q[rd_ptr_q];
    assign o_count      = count_q;
    assign o_stall_cnt  = stall_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (i_clr_stats) begin
            stall_d = '0;
        end else if (o_valid && !i_ready && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end
    end

    // Payload storage is deliberately left unreset; only the control state is.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: tb/tb_stage_buffer.sv
// Directed bench for stage_buffer using three configurations: DEPTH=2 registered,
// DEPTH=4 registered with a 4-bit stall counter, and DEPTH=2 with bypass.
module tb_stage_buffer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: DEPTH=2, BYPASS=0
    logic        a_iv = 0, a_ir = 0, a_fl = 0, a_clr = 0;
    logic [7:0]  a_id = '0;
    logic        a_or, a_ov;
    logic [7:0]  a_od;
    logic [1:0]  a_cnt;
    logic [15:0] a_st;

    // Instance B: DEPTH=4, BYPASS=0, STALL_W=4
    logic        b_iv = 0, b_ir = 0, b_fl = 0, b_clr = 0;
    logic [7:0]  b_id = '0;
    logic        b_or, b_ov;
    logic [7:0]  b_od;
    logic [2:0]  b_cnt;
    logic [3:0]  b_st;

    // Instance C: DEPTH=2, BYPASS=1
    logic        c_iv = 0, c_ir = 0, c_fl = 0, c_clr = 0;
    logic [15:0] c_id = '0;
    logic        c_or, c_ov;
    logic [15:0] c_od;
    logic [1:0]  c_cnt;
    logic [15:0] c_st;

    stage_buffer #(.WIDTH(8), .DEPTH(2), .BYPASS(0), .STALL_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .i_valid(a_iv), .o_ready(a_or), .i_data(a_id),
        .o_valid(a_ov), .i_ready(a_ir), .o_data(a_od), .i_flush(a_fl),
        .i_clr_stats(a_clr), .o_count(a_cnt), .o_stall_cnt(a_st));

    stage_buffer #(.WIDTH(8), .DEPTH(4), .BYPASS(0), .STALL_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .i_valid(b_iv), .o_ready(b_or), .i_data(b_id),
        .o_valid(b_ov), .i_ready(b_ir), .o_data(b_od), .i_flush(b_fl),
        .i_clr_stats(b_clr), .o_count(b_cnt), .o_stall_cnt(b_st));

    stage_buffer #(.WIDTH(16), .DEPTH(2), .BYPASS(1), .STALL_W(16)) u_c (
        .clk(clk), .rst_n(rst_n), .i_valid(c_iv), .o_ready(c_or), .i_data(c_id),
        .o_valid(c_ov), .i_ready(c_ir), .o_data(c_od), .i_flush(c_fl),
        .i_clr_stats(c_clr), .o_count(c_cnt), .o_stall_cnt(c_st));

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        checks++;
        if (a_or !== 1'b1 || a_ov !== 1'b0 || a_cnt !== 2'd0 || a_st !== 16'd0) begin
            errors++;
            $display("FAIL reset_a: ready=%b valid=%b count=%0d stall=%0d, expected 1 0 0 0",
                     a_or, a_ov, a_cnt, a_st);
        end
        checks++;
        if (b_or !== 1'b1 || b_ov !== 1'b0 || b_cnt !== 3'd0 || b_st !== 4'd0) begin
            errors++;
            $display("FAIL reset_b: ready=%b valid=%b count=%0d stall=%0d, expected 1 0 0 0",
                     b_or, b_ov, b_cnt, b_st);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [4];
        vals[0] = 8'h0A; vals[1] = 8'h0B; vals[2] = 8'h0C; vals[3] = 8'h0D;
        b_ir = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_iv = 1'b1;
            b_id = vals[i];
            step();
        end
        b_iv = 1'b0;
        #1;
        checks++;
        if (b_cnt !== 3'd4 || b_or !== 1'b0 || b_st !== 4'd3) begin
            errors++;
            $display("FAIL fill: count=%0d ready=%b stall=%0d, expected 4 0 3", b_cnt, b_or, b_st);
        end
        b_ir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (b_ov !== 1'b1 || b_od !== vals[i]) begin
                errors++;
                $display("FAIL drain[%0d]: valid=%b data=%h, expected 1 %h", i, b_ov, b_od, vals[i]);
            end
            step();
        end
        checks++;
        if (b_cnt !== 3'd0 || b_ov !== 1'b0 || b_st !== 4'd3) begin
            errors++;
            $display("FAIL drained: count=%0d valid=%b stall=%0d, expected 0 0 3", b_cnt, b_ov, b_st);
        end
        b_ir = 1'b0;
    endtask

    task automatic test_push_pop();
        a_ir = 1'b0; a_iv = 1'b1; a_id = 8'h04;
        step();
        a_id = 8'h05; a_ir = 1'b1;
        #1;
        checks++;
        if (a_od !== 8'h04 || a_ov !== 1'b1) begin
            errors++;
            $display("FAIL pp_head: data=%h valid=%b, expected 04 1", a_od, a_ov);
        end
        step();
        checks++;
        if (a_cnt !== 2'd1 || a_od !== 8'h05) begin
            errors++;
            $display("FAIL pp_same: count=%0d data=%h, expected 1 05", a_cnt, a_od);
        end
        a_id = 8'h06; a_ir = 1'b0;
        step();
        a_id = 8'h07; a_ir = 1'b1;
        #1;
        checks++;
        if (a_cnt !== 2'd2 || a_or !== 1'b0) begin
            errors++;
            $display("FAIL pp_full: count=%0d ready=%b, expected 2 0", a_cnt, a_or);
        end
        step();
        a_iv = 1'b0;
        checks++;
        if (a_cnt !== 2'd1 || a_od !== 8'h06) begin
            errors++;
            $display("FAIL pp_refused: count=%0d data=%h, expected 1 06", a_cnt, a_od);
        end
        step();
        step();
        checks++;
        if (a_cnt !== 2'd0 || a_ov !== 1'b0) begin
            errors++;
            $display("FAIL pp_drain: count=%0d valid=%b, expected 0 0", a_cnt, a_ov);
        end
        a_ir = 1'b0;
    endtask

    task automatic test_flush();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        b_ir = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_iv = 1'b1;
            b_id = vals[i];
            step();
        end
        b_id = 8'h44; b_fl = 1'b1;
        #1;
        checks++;
        if (b_ov !== 1'b0 || b_cnt !== 3'd3) begin
            errors++;
            $display("FAIL flush_same: valid=%b count=%0d, expected 0 3", b_ov, b_cnt);
        end
        step();
        b_fl = 1'b0; b_iv = 1'b0;
        #1;
        checks++;
        if (b_cnt !== 3'd0 || b_ov !== 1'b0 || b_or !== 1'b1) begin
            errors++;
            $display("FAIL flush_next: count=%0d valid=%b ready=%b, expected 0 0 1", b_cnt, b_ov, b_or);
        end
        b_iv = 1'b1; b_id = 8'h55;
        step();
        b_iv = 1'b0;
        checks++;
        if (b_cnt !== 3'd1 || b_od !== 8'h55) begin
            errors++;
            $display("FAIL flush_after: count=%0d data=%h, expected 1 55", b_cnt, b_od);
        end
        b_ir = 1'b1;
        step();
        b_ir = 1'b0;
    endtask

    task automatic test_bypass();
        c_iv = 1'b1; c_id = 16'h1234; c_ir = 1'b1;
        #1;
        checks++;
        if (c_ov !== 1'b1 || c_od !== 16'h1234) begin
            errors++;
            $display("FAIL bypass_comb: valid=%b data=%h, expected 1 1234", c_ov, c_od);
        end
        step();
        checks++;
        if (c_cnt !== 2'd0) begin
            errors++;
            $display("FAIL bypass_count: count=%0d, expected 0", c_cnt);
        end
        c_id = 16'hBEEF; c_ir = 1'b0;
        step();
        c_iv = 1'b0;
        #1;
        checks++;
        if (c_cnt !== 2'd1 || c_od !== 16'hBEEF || c_ov !== 1'b1) begin
            errors++;
            $display("FAIL bypass_stall: count=%0d data=%h valid=%b, expected 1 beef 1", c_cnt, c_od, c_ov);
        end
        c_ir = 1'b1;
        step();
        c_ir = 1'b0;
    endtask

    task automatic test_stall_sat();
        b_clr = 1'b1;
        step();
        b_clr = 1'b0;
        b_iv = 1'b1; b_id = 8'h77; b_ir = 1'b0;
        step();
        b_iv = 1'b0;
        repeat (20) step();
        checks++;
        if (b_st !== 4'd15) begin
            errors++;
            $display("FAIL stall_sat: stall=%0d, expected 15", b_st);
        end
        b_clr = 1'b1;
        step();
        b_clr = 1'b0;
        checks++;
        if (b_st !== 4'd0) begin
            errors++;
            $display("FAIL stall_clr: stall=%0d, expected 0", b_st);
        end
        b_ir = 1'b1;
        step();
        b_ir = 1'b0;
    endtask

    task automatic test_reset_mid();
        a_iv = 1'b1; a_id = 8'h99; a_ir = 1'b0;
        step();
        a_iv = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_cnt !== 2'd0 || a_ov !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: count=%0d valid=%b, expected 0 0", a_cnt, a_ov);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (a_ov !== 1'b0 || a_st !== 16'd0) begin
            errors++;
            $display("FAIL reset_release: valid=%b stall=%0d, expected 0 0", a_ov, a_st);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_push_pop();
        test_flush();
        test_bypass();
        test_stall_sat();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
